// File: rtl/fault_trip_sequencer.sv
// Fault front end and trip sequencer: per-channel debounce, first-fault latch,
// blinking warning phase, relay trip, operator clear and re-arm hold-off.
module fault_trip_sequencer #(
    parameter int N_CH        = 4,
    parameter int DEBOUNCE    = 8,
    parameter int RELAY_DELAY = 16,
    parameter int HOLDOFF     = 32,
    parameter int BLINK_HALF  = 4,
    parameter int CNT_W       = 8,
    localparam int ID_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  raw_fault,
    input  logic [N_CH-1:0]  fault_mask,
    input  logic             clear_req,
    output logic             light,
    output logic             relay_driver,
    output logic             fault_valid,
    output logic [ID_W-1:0]  fault_id,
    output logic [CNT_W-1:0] trip_count,
    output logic             clear_rejected,
    output logic [1:0]       state_o
);

    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam int TMAX  = (RELAY_DELAY > HOLDOFF) ? RELAY_DELAY : HOLDOFF;
    localparam int TMR_W = $clog2(TMAX + 1);
    localparam int BL_W  = $clog2(BLINK_HALF + 1);

    localparam logic [DB_W-1:0]  DB_MAX     = DB_W'(DEBOUNCE);
    localparam logic [TMR_W-1:0] DELAY_LOAD = TMR_W'(RELAY_DELAY - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD  = TMR_W'(HOLDOFF - 1);
    localparam logic [BL_W-1:0]  BLINK_LOAD = BL_W'(BLINK_HALF - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PENDING  = 2'd1;
    localparam logic [1:0] ST_TRIPPED  = 2'd2;
    localparam logic [1:0] ST_CLEARING = 2'd3;

    logic [N_CH-1:0]  confirmed;
    logic             fault_any;
    logic [ID_W-1:0]  lowest_id;
    logic [1:0]       state;
    logic [TMR_W-1:0] timer;
    logic [BL_W-1:0]  blink_cnt;

    // A confirmed channel stays confirmed only while every sample keeps it high and unmasked.
    for (genvar g = 0; g < N_CH; g++) begin : g_debounce
        logic [DB_W-1:0] db_cnt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                db_cnt <= '0;
            end else if (raw_fault[g] && !fault_mask[g]) begin
                if (db_cnt != DB_MAX) begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end

        assign confirmed[g] = (db_cnt == DB_MAX);
    end

    assign fault_any = |confirmed;

    always_comb begin
        lowest_id = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (confirmed[i]) begin
                lowest_id = ID_W'(i);
            end
        end
    end

    assign state_o = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            timer          <= '0;
            blink_cnt      <= '0;
            light          <= 1'b0;
            relay_driver   <= 1'b0;
            fault_valid    <= 1'b0;
            fault_id       <= '0;
            trip_count     <= '0;
            clear_rejected <= 1'b0;
        end else begin
            clear_rejected <= 1'b0;
            case (state)
                ST_IDLE: begin
                    light        <= 1'b0;
                    relay_driver <= 1'b0;
                    if (fault_any) begin
                        state       <= ST_PENDING;
                        fault_id    <= lowest_id;
                        fault_valid <= 1'b1;
                        timer       <= DELAY_LOAD;
                        blink_cnt   <= BLINK_LOAD;
                        light       <= 1'b1;
                    end
                end
                // Once pending, the trip always completes regardless of faults or clear.
                ST_PENDING: begin
                    relay_driver <= 1'b0;
                    if (timer == '0) begin
                        state        <= ST_TRIPPED;
                        relay_driver <= 1'b1;
                        light        <= 1'b1;
                        if (trip_count != '1) begin
                            trip_count <= trip_count + 1'b1;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                        if (blink_cnt == '0) begin
                            light     <= ~light;
                            blink_cnt <= BLINK_LOAD;
                        end else begin
                            blink_cnt <= blink_cnt - 1'b1;
                        end
                    end
                end
                ST_TRIPPED: begin
                    if (clear_req && !fault_any) begin
                        state        <= ST_CLEARING;
                        relay_driver <= 1'b0;
                        light        <= 1'b0;
                        fault_valid  <= 1'b0;
                        timer        <= HOLD_LOAD;
                    end else if (clear_req) begin
                        clear_rejected <= 1'b1;
                    end
                end
                ST_CLEARING: begin
                    relay_driver <= 1'b0;
                    light        <= 1'b0;
                    if (timer == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fault_trip_sequencer.sv
// Scoreboard bench for fault_trip_sequencer: a cycle-level reference model pushes
// expected outputs per edge; a monitor pops and compares after each rising edge.
module tb_fault_trip_sequencer;

    localparam int N_CH        = 4;
    localparam int DEBOUNCE    = 8;
    localparam int RELAY_DELAY = 16;
    localparam int HOLDOFF     = 32;
    localparam int BLINK_HALF  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N_CH-1:0] raw_fault;
    logic [N_CH-1:0] fault_mask;
    logic            clear_req;
    logic            light, relay_driver, fault_valid, clear_rejected;
    logic [1:0]      fault_id;
    logic [7:0]      trip_count;
    logic [1:0]      state_o;

    logic            s_light, s_relay, s_valid, s_rejected;
    logic [1:0]      s_id;
    logic [1:0]      s_count;
    logic [1:0]      s_state;

    fault_trip_sequencer dut (
        .clk(clk), .reset(reset), .raw_fault(raw_fault), .fault_mask(fault_mask),
        .clear_req(clear_req), .light(light), .relay_driver(relay_driver),
        .fault_valid(fault_valid), .fault_id(fault_id), .trip_count(trip_count),
        .clear_rejected(clear_rejected), .state_o(state_o)
    );

    fault_trip_sequencer #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .raw_fault(raw_fault), .fault_mask(fault_mask),
        .clear_req(clear_req), .light(s_light), .relay_driver(s_relay),
        .fault_valid(s_valid), .fault_id(s_id), .trip_count(s_count),
        .clear_rejected(s_rejected), .state_o(s_state)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE = 0, M_PENDING = 1, M_TRIPPED = 2, M_CLEARING = 3} mstate_t;

    typedef struct {
        int state;
        int light;
        int relay;
        int valid;
        int id;
        int count;
        int count_small;
        int rejected;
    } exp_t;

    exp_t    exp_q[$];
    mstate_t m_state;
    int      m_run[N_CH];
    int      m_elapsed;
    int      m_id;
    int      m_valid;
    int      m_trips;
    int      m_rejected;
    int      compared   = 0;
    int      mismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void modelReset();
        m_state = M_IDLE;
        foreach (m_run[i]) m_run[i] = 0;
        m_elapsed  = 0;
        m_id       = 0;
        m_valid    = 0;
        m_trips    = 0;
        m_rejected = 0;
    endfunction

    // Advances the reference one edge using the inputs sampled at that edge.
    function automatic void modelStep(input logic [N_CH-1:0] raw, input logic [N_CH-1:0] mask, input logic clr);
        bit   any = 0;
        int   lowest = -1;
        exp_t e;
        for (int i = 0; i < N_CH; i++) begin
            if (m_run[i] >= DEBOUNCE) begin
                any = 1;
                if (lowest < 0) lowest = i;
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            m_run[i] = (raw[i] && !mask[i]) ? ((m_run[i] < 1000) ? m_run[i] + 1 : 1000) : 0;
        end
        m_rejected = 0;
        case (m_state)
            M_IDLE: if (any) begin
                m_state = M_PENDING; m_id = lowest; m_valid = 1; m_elapsed = 0;
            end
            M_PENDING: begin
                m_elapsed++;
                if (m_elapsed == RELAY_DELAY) begin
                    m_state = M_TRIPPED; m_trips++;
                end
            end
            M_TRIPPED: begin
                if (clr && !any) begin
                    m_state = M_CLEARING; m_valid = 0; m_elapsed = 0;
                end else if (clr) begin
                    m_rejected = 1;
                end
            end
            M_CLEARING: begin
                m_elapsed++;
                if (m_elapsed == HOLDOFF) m_state = M_IDLE;
            end
            default: ;
        endcase
        e.state       = int'(m_state);
        e.light       = (m_state == M_TRIPPED) ? 1 :
                        (m_state == M_PENDING) ? (((m_elapsed / BLINK_HALF) % 2) == 0) : 0;
        e.relay       = (m_state == M_TRIPPED);
        e.valid       = m_valid;
        e.id          = m_id;
        e.count       = (m_trips > 255) ? 255 : m_trips;
        e.count_small = (m_trips > 3) ? 3 : m_trips;
        e.rejected    = m_rejected;
        exp_q.push_back(e);
    endfunction

    task automatic applyStimulus(input logic [N_CH-1:0] raw, input logic [N_CH-1:0] mask, input logic clr);
        @(negedge clk);
        raw_fault  = raw;
        fault_mask = mask;
        clear_req  = clr;
        modelStep(raw, mask, clr);
    endtask

    task automatic holdCycles(input logic [N_CH-1:0] raw, input logic [N_CH-1:0] mask, input int n);
        for (int k = 0; k < n; k++) applyStimulus(raw, mask, 1'b0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_state"}, state_o, 0);
        checkOutput({tag, "_relay"}, relay_driver, 0);
        checkOutput({tag, "_light"}, light, 0);
        checkOutput({tag, "_valid"}, fault_valid, 0);
        checkOutput({tag, "_id"}, fault_id, 0);
        checkOutput({tag, "_count"}, trip_count, 0);
        checkOutput({tag, "_count_small"}, s_count, 0);
        checkOutput({tag, "_rejected"}, clear_rejected, 0);
    endtask

    task automatic releaseReset();
        @(negedge clk);
        reset      = 1'b0;
        raw_fault  = '0;
        fault_mask = '0;
        clear_req  = 1'b0;
        modelReset();
        modelStep('0, '0, 1'b0);
    endtask

    // Reset lands between edges; outputs must drop without waiting for a clock.
    task automatic resetMidCycle();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkResetState("async_reset");
        modelReset();
        @(posedge clk);
        releaseReset();
    endtask

    task automatic tripAndClear(input logic [N_CH-1:0] raw);
        holdCycles(raw, '0, DEBOUNCE + 1 + RELAY_DELAY + 2);
        holdCycles('0, '0, 2);
        applyStimulus('0, '0, 1'b1);
        holdCycles('0, '0, HOLDOFF + 2);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("state", state_o, e.state);
                checkOutput("light", light, e.light);
                checkOutput("relay", relay_driver, e.relay);
                checkOutput("fault_valid", fault_valid, e.valid);
                checkOutput("fault_id", fault_id, e.id);
                checkOutput("trip_count", trip_count, e.count);
                checkOutput("trip_count_small", s_count, e.count_small);
                checkOutput("clear_rejected", clear_rejected, e.rejected);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        reset      = 1'b1;
        raw_fault  = '0;
        fault_mask = '0;
        clear_req  = 1'b0;
        modelReset();
        #1;
        checkResetState("power_on_reset");
        repeat (3) @(posedge clk);
        releaseReset();

        holdCycles('0, '0, 100);

        // Single channel trip, rejected clear while the fault persists, then a clean clear.
        holdCycles(4'b0100, '0, DEBOUNCE + 1 + RELAY_DELAY + 3);
        applyStimulus(4'b0100, '0, 1'b1);
        holdCycles(4'b0100, '0, 2);
        holdCycles('0, '0, 2);
        applyStimulus('0, '0, 1'b1);
        holdCycles('0, '0, HOLDOFF + 3);

        // Pulses one short of the debounce length, and a masked stuck channel.
        for (int r = 0; r < 5; r++) begin
            holdCycles(4'b0010, '0, DEBOUNCE - 1);
            holdCycles('0, '0, 1);
        end
        holdCycles(4'b1000, 4'b1000, 40);

        // Simultaneous confirmation picks the lowest channel.
        holdCycles(4'b1001, '0, DEBOUNCE + 1 + RELAY_DELAY + 2);
        applyStimulus(4'b1001, '0, 1'b1);
        holdCycles(4'b1001, '0, 3);

        // Clear, then a fault reconfirms during hold-off and trips right after re-arm.
        holdCycles('0, '0, 10);
        applyStimulus('0, '0, 1'b1);
        holdCycles('0, '0, 5);
        holdCycles(4'b0100, '0, HOLDOFF + RELAY_DELAY);
        holdCycles('0, '0, 2);
        applyStimulus('0, '0, 1'b1);
        holdCycles('0, '0, HOLDOFF + 2);

        holdCycles(4'b0010, '0, DEBOUNCE + 1 + RELAY_DELAY + 4);
        resetMidCycle();

        for (int t = 0; t < 5; t++) tripAndClear(4'b0001 << (t % N_CH));

        for (int ep = 0; ep < 60; ep++) begin
            logic [N_CH-1:0] raw, mask;
            int len;
            raw  = ($urandom_range(0, 1) == 1) ? N_CH'($urandom_range(1, 15)) : '0;
            mask = ($urandom_range(0, 3) == 0) ? N_CH'($urandom_range(0, 15)) : '0;
            len  = $urandom_range(1, 40);
            for (int k = 0; k < len; k++) applyStimulus(raw, mask, ($urandom_range(0, 5) == 0));
        end

        resetMidCycle();
        holdCycles('0, '0, 3);
        repeat (3) @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
